// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit Harvard load/store CPU: opcodes,
// branch-condition codes, sequencer states and instruction field helpers.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_IMM  = 4'hC;
  localparam logic [3:0] OP_IMMH = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch condition selected by the d field; anything above BR_CARRY is unconditional.
  localparam logic [3:0] BR_ZERO  = 4'h0;
  localparam logic [3:0] BR_NZERO = 4'h1;
  localparam logic [3:0] BR_NEG   = 4'h2;
  localparam logic [3:0] BR_CARRY = 4'h3;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  function automatic logic [3:0] irOp(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [3:0] irRd(input logic [15:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [3:0] irRs(input logic [15:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [3:0] irRt(input logic [15:0] ir);
    return ir[3:0];
  endfunction

  function automatic logic [7:0] irImm8(input logic [15:0] ir);
    return ir[7:0];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes 0000-0111; Z and N always reflect the result,
// C is the carry/borrow/shifted-out bit (zero for logic ops and NOT).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_result,
  output logic        o_carry,
  output logic        o_zero,
  output logic        o_neg
);

  logic [16:0] w_sum;
  logic [16:0] w_diff;

  // Widened by one bit so bit 16 is the carry out / borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = 16'h0000;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[15:0];
        o_carry  = w_sum[16];
      end
      OP_SUB: begin
        o_result = w_diff[15:0];
        o_carry  = w_diff[16];
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_a;
      OP_SHL: begin
        o_result = {i_a[14:0], 1'b0};
        o_carry  = i_a[15];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[15:1]};
        o_carry  = i_a[0];
      end
      default: begin
        o_result = 16'h0000;
        o_carry  = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_result == 16'h0000);
  assign o_neg  = o_result[15];

endmodule

// File: rtl/cpu.sv
// 16-bit load/store CPU: register file, PC, flags, FETCH/EXECUTE sequencer
// and bus control for synchronous instruction and data memories.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  output logic [15:0] IA,
  input  logic [15:0] ID,
  output logic [15:0] DA,
  inout  wire  [15:0] DD,
  output logic        RW
);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_regs [16];
  logic        r_z;
  logic        r_n;
  logic        r_c;
  logic        r_halted;

  state_t      w_nextState;
  logic [3:0]  w_op;
  logic [3:0]  w_d;
  logic [3:0]  w_s;
  logic [3:0]  w_t;
  logic [7:0]  w_imm;
  logic [15:0] w_rs;
  logic [15:0] w_rt;
  logic [15:0] w_rd;
  logic [15:0] w_aluResult;
  logic        w_aluCarry;
  logic        w_aluZero;
  logic        w_aluNeg;
  logic        w_isAlu;
  logic        w_brTaken;
  logic        w_regWe;
  logic [15:0] w_wdata;
  logic [15:0] w_pcNext;
  logic        w_isStore;

  assign w_op  = irOp(r_ir);
  assign w_d   = irRd(r_ir);
  assign w_s   = irRs(r_ir);
  assign w_t   = irRt(r_ir);
  assign w_imm = irImm8(r_ir);

  // R0 is never written, so it keeps its reset value of zero.
  assign w_rs = r_regs[w_s];
  assign w_rt = r_regs[w_t];
  assign w_rd = r_regs[w_d];

  assign w_isAlu = (w_op[3] == 1'b0);

  cpu_alu u_alu (
    .i_op    (w_op),
    .i_a     (w_rs),
    .i_b     (w_rt),
    .o_result(w_aluResult),
    .o_carry (w_aluCarry),
    .o_zero  (w_aluZero),
    .o_neg   (w_aluNeg)
  );

  always_comb begin
    w_brTaken = 1'b1;
    case (w_d)
      BR_ZERO:  w_brTaken = r_z;
      BR_NZERO: w_brTaken = ~r_z;
      BR_NEG:   w_brTaken = r_n;
      BR_CARRY: w_brTaken = r_c;
      default:  w_brTaken = 1'b1;
    endcase
  end

  always_comb begin
    w_regWe  = 1'b0;
    w_wdata  = w_aluResult;
    w_pcNext = r_pc + 16'd1;
    case (w_op)
      OP_JMP:  w_pcNext = w_rt;
      OP_BR:   if (w_brTaken) w_pcNext = w_rt;
      OP_LD: begin
        w_regWe = 1'b1;
        w_wdata = DD;
      end
      OP_IMM: begin
        w_regWe = 1'b1;
        w_wdata = {8'h00, w_imm};
      end
      OP_IMMH: begin
        w_regWe = 1'b1;
        w_wdata = {w_imm, w_rd[7:0]};
      end
      OP_HALT: w_pcNext = r_pc;
      OP_ST, OP_NOP: ;
      default: w_regWe = w_isAlu;
    endcase
  end

  // Sequencer: a halted CPU parks in FETCH until reset.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:   if (!r_halted) w_nextState = EXECUTE;
      EXECUTE: w_nextState = FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST) r_state <= FETCH;
    else      r_state <= w_nextState;
  end

  always_ff @(posedge CK) begin
    if (!RST) begin
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= 16'h0000;
    end else if (r_state == FETCH) begin
      if (!r_halted) r_ir <= ID;
    end else begin
      r_pc <= w_pcNext;
      if (w_regWe && (w_d != 4'd0)) r_regs[w_d] <= w_wdata;
      if (w_isAlu) begin
        r_z <= w_aluZero;
        r_n <= w_aluNeg;
        if (w_op != OP_NOT) r_c <= w_aluCarry;
      end
      if (w_op == OP_HALT) r_halted <= 1'b1;
    end
  end

  // Bus outputs are forced idle while reset is held so an interrupted ST never strobes.
  assign w_isStore = RST && (r_state == EXECUTE) && (w_op == OP_ST);
  assign IA = r_pc;
  assign RW = ~w_isStore;
  assign DA = RST ? w_rt : 16'h0000;
  assign DD = w_isStore ? w_rs : 16'hzzzz;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: synchronous instruction/data memory models, an
// instruction-level reference model, directed programs and random programs.
module tb_cpu;

  logic        CK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] IA;
  logic [15:0] ID;
  logic [15:0] DA;
  wire  [15:0] DD;
  logic        RW;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] rdData;
  logic        checkEn = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural registers plus which half of the
  // two-clock instruction slot the CPU is in.
  logic [15:0] mR [16];
  logic [15:0] mPc;
  logic [15:0] mIr;
  logic        mZ, mN, mC, mHalted, mExec;

  always #10 CK = ~CK;

  cpu #(.RESET_PC(16'h0000)) dut (
    .CK (CK),
    .RST(RST),
    .IA (IA),
    .ID (ID),
    .DA (DA),
    .DD (DD),
    .RW (RW)
  );

  // Memories sample addresses on the falling edge and return data after it.
  assign DD = RW ? rdData : 16'hzzzz;

  always @(negedge CK) begin
    ID     <= imem[IA[7:0]];
    rdData <= dmem[DA[7:0]];
    if (RW === 1'b0) dmem[DA[7:0]] <= DD;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input int cycles);
    @(negedge CK);
    #2;
    RST = rstVal;
    repeat (cycles) @(negedge CK);
  endtask

  task automatic modelWrite(input logic [3:0] d, input logic [15:0] v);
    if (d != 4'd0) mR[d] = v;
  endtask

  task automatic modelAlu(input logic [3:0] d, input logic [15:0] v);
    modelWrite(d, v);
    mZ = (v == 16'h0000);
    mN = v[15];
  endtask

  task automatic modelStep();
    logic [3:0]  op, d, s, t;
    logic [15:0] a, b, nextPc;
    logic [16:0] wide;
    logic        taken;
    if (!RST) begin
      mPc = 16'h0000; mIr = 16'h0000; mExec = 1'b0; mHalted = 1'b0;
      mZ = 1'b0; mN = 1'b0; mC = 1'b0;
      for (int i = 0; i < 16; i++) mR[i] = 16'h0000;
    end else if (!mExec) begin
      if (!mHalted) begin
        mIr   = imem[mPc[7:0]];
        mExec = 1'b1;
      end
    end else begin
      op = mIr[15:12]; d = mIr[11:8]; s = mIr[7:4]; t = mIr[3:0];
      a = mR[s]; b = mR[t];
      nextPc = mPc + 16'd1;
      case (op)
        4'h0: begin wide = a + b; modelAlu(d, wide[15:0]); mC = wide[16]; end
        4'h1: begin modelAlu(d, a - b); mC = (a < b); end
        4'h2: begin modelAlu(d, a & b); mC = 1'b0; end
        4'h3: begin modelAlu(d, a | b); mC = 1'b0; end
        4'h4: begin modelAlu(d, a ^ b); mC = 1'b0; end
        4'h5: modelAlu(d, ~a);
        4'h6: begin modelAlu(d, a << 1); mC = a[15]; end
        4'h7: begin modelAlu(d, a >> 1); mC = a[0]; end
        4'h8: nextPc = b;
        4'h9: begin
          taken = (d == 0) ? mZ : (d == 1) ? !mZ : (d == 2) ? mN : (d == 3) ? mC : 1'b1;
          if (taken) nextPc = b;
        end
        4'hB: modelWrite(d, dmem[b[7:0]]);
        4'hC: modelWrite(d, {8'h00, mIr[7:0]});
        4'hD: modelWrite(d, {mIr[7:0], mR[d][7:0]});
        4'hF: begin mHalted = 1'b1; nextPc = mPc; end
        default: ;
      endcase
      mPc   = nextPc;
      mExec = 1'b0;
    end
  endtask

  always @(posedge CK) modelStep();

  // Every falling edge: bus outputs must match what the model says this cycle does.
  always @(negedge CK) begin
    if (checkEn) begin
      if (!RST) begin
        checkOutput("rstRW", {15'b0, RW}, 16'h0001);
        checkOutput("rstDA", DA, 16'h0000);
      end else if (!mExec) begin
        checkOutput("fetchIA", IA, mPc);
        checkOutput("fetchRW", {15'b0, RW}, 16'h0001);
      end else begin
        checkOutput("execDA", DA, mR[mIr[3:0]]);
        checkOutput("execRW", {15'b0, RW}, {15'b0, (mIr[15:12] != 4'hA)});
        if (mIr[15:12] == 4'hA) checkOutput("stDD", DD, mR[mIr[7:4]]);
      end
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hF000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic restart();
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 0);
  endtask

  initial begin
    logic [15:0] sumProg [13];
    logic [15:0] flagProg [16];
    logic [15:0] r;
    bit found;

    clearMem();

    // Reset held for 5 cycles, then first fetch from address 0.
    repeat (5) @(posedge CK);
    checkEn = 1'b1;
    @(negedge CK); #1;
    checkOutput("resetIA", IA, 16'h0000);
    checkOutput("resetRW", {15'b0, RW}, 16'h0001);
    checkOutput("resetDA", DA, 16'h0000);
    applyStimulus(1'b1, 0);
    @(negedge CK); #1;
    checkOutput("firstFetchIA", IA, 16'h0000);

    // Sum loop: 1+2+...+9 stored to address 0.
    clearMem();
    sumProg = '{16'hC100, 16'hC201, 16'hC301, 16'hC409, 16'hC50C, 16'hC607, 16'hC700,
                16'h0112, 16'h0223, 16'h1443, 16'h9005, 16'h8006, 16'hA017};
    for (int i = 0; i < 13; i++) imem[i] = sumProg[i];
    restart();
    found = 1'b0;
    for (int i = 0; i < 125 && !found; i++) begin
      @(negedge CK); #1;
      if (RW === 1'b0) found = 1'b1;
    end
    checkOutput("sumStrobeSeen", {15'b0, found}, 16'h0001);
    checkOutput("sumDA", DA, 16'h0000);
    checkOutput("sumDD", DD, 16'd45);
    checkOutput("modelSum", mR[1], 16'd45);
    repeat (4) @(negedge CK);
    checkOutput("sumMem", dmem[0], 16'd45);

    // LD/ST round trip.
    clearMem();
    dmem[1] = 16'd15;
    imem[0] = 16'hC701; imem[1] = 16'hB207; imem[2] = 16'h0322;
    imem[3] = 16'hC802; imem[4] = 16'hA038;
    restart();
    repeat (20) @(negedge CK);
    checkOutput("ldstMem", dmem[2], 16'd30);
    checkOutput("modelLd", mR[3], 16'd30);

    // Flags, branches, IMMH, R0 and 0xFFFF+1 edge cases, ending in HALT at 52.
    clearMem();
    dmem[3] = 16'h7777;
    dmem[4] = 16'hBEEF;
    flagProg = '{16'hC103, 16'hC205, 16'hC414, 16'hC601, 16'h1312, 16'hA030, 16'h9004,
                 16'hC711, 16'hA076, 16'h9304, 16'hC7EE, 16'hA076, 16'hF000,
                 16'hC81E, 16'h9208, 16'hF000};
    for (int i = 0; i < 13; i++) imem[i] = flagProg[i];
    imem[20] = flagProg[13]; imem[21] = flagProg[14]; imem[22] = flagProg[15];
    imem[30] = 16'hC934; imem[31] = 16'hD912; imem[32] = 16'hCA02; imem[33] = 16'hA09A;
    imem[34] = 16'hC055; imem[35] = 16'hCB03; imem[36] = 16'hA00B; imem[37] = 16'hCCFF;
    imem[38] = 16'hDCFF; imem[39] = 16'hCD01; imem[40] = 16'hCF32; imem[41] = 16'h0ECD;
    imem[42] = 16'h900F; imem[43] = 16'hF000;
    imem[50] = 16'hCB04; imem[51] = 16'hA0EB; imem[52] = 16'hF000;
    restart();
    repeat (80) @(negedge CK);
    #1;
    checkOutput("subResult", dmem[0], 16'hFFFE);
    checkOutput("brPath", dmem[1], 16'h0011);
    checkOutput("immhR9", dmem[2], 16'h1234);
    checkOutput("r0Zero", dmem[3], 16'h0000);
    checkOutput("addWrap", dmem[4], 16'h0000);
    checkOutput("modelR9", mR[9], 16'h1234);
    checkOutput("modelR0", mR[0], 16'h0000);
    checkOutput("modelFlags", {13'b0, mZ, mN, mC}, 16'h0005);
    for (int i = 0; i < 20; i++) begin
      @(negedge CK); #1;
      checkOutput("haltIA", IA, 16'd52);
      checkOutput("haltRW", {15'b0, RW}, 16'h0001);
    end

    // Reset during EXECUTE of an ST: no strobe, restart at 0.
    clearMem();
    dmem[0] = 16'h4242;
    imem[0] = 16'hC105; imem[1] = 16'hA010;
    restart();
    for (int i = 0; i < 20; i++) begin
      @(posedge CK); #1;
      if (mExec && mIr[15:12] == 4'hA) break;
    end
    checkOutput("midRstInSt", {15'b0, mExec}, 16'h0001);
    RST = 1'b0;
    @(negedge CK); #1;
    checkOutput("midRstRW", {15'b0, RW}, 16'h0001);
    @(posedge CK);
    applyStimulus(1'b1, 0);
    @(negedge CK); #1;
    checkOutput("midRstIA", IA, 16'h0000);
    checkOutput("midRstMem", dmem[0], 16'h4242);

    // Random programs, checked cycle by cycle against the model.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) begin
        r = 16'($urandom);
        imem[i] = {4'($urandom_range(0, 14)), r[11:0]};
        dmem[i] = 16'($urandom);
      end
      restart();
      repeat (300) @(negedge CK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
